// File: rtl/rotary_position_accumulator.sv
// rotary_position_accumulator
//   Turns the rotary decoder's one-cycle count/direction/error strobes into a
//   bounded position. It can either wrap or saturate at the bounds, and it
//   takes larger steps when same-direction detents arrive in quick succession.
//   It also provides a preload, a change strobe and a saturating decoder-error
//   counter.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        asynchronous active-high reset
//   i_cnt        one-cycle count pulse from the decoder
//   i_cnt_cw     direction of i_cnt (1 = clockwise / increment)
//   i_cnt_err    one-cycle decoder error strobe
//   i_load       synchronous preload request (highest priority)
//   iv_load_val  preload value, clamped into [POS_MIN, POS_MAX]
//   i_err_clr    synchronous clear of the error counter
//   ov_pos       current position
//   o_changed    one-cycle strobe when ov_pos took a different value
//   o_at_min     ov_pos == POS_MIN
//   o_at_max     ov_pos == POS_MAX
//   ov_err_cnt   saturating count of i_cnt_err strobes
module rotary_position_accumulator #(
  parameter int WIDTH        = 8,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 255,
  parameter int WRAP         = 1,
  parameter int ACCEL_WINDOW = 1000,
  parameter int ACCEL_RUN    = 2,
  parameter int ACCEL_STEP   = 4,
  parameter int ERR_WIDTH    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cnt,
  input  logic                 i_cnt_cw,
  input  logic                 i_cnt_err,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     iv_load_val,
  input  logic                 i_err_clr,
  output logic [WIDTH-1:0]     ov_pos,
  output logic                 o_changed,
  output logic                 o_at_min,
  output logic                 o_at_max,
  output logic [ERR_WIDTH-1:0] ov_err_cnt
);

  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam int RW = $clog2(ACCEL_RUN + 1);
  localparam int XW = WIDTH + 2;

  localparam logic [TW-1:0]        WIN    = TW'(ACCEL_WINDOW);
  localparam logic [RW-1:0]        RUN_T  = RW'(ACCEL_RUN);
  localparam logic [WIDTH-1:0]     MIN_V  = WIDTH'(POS_MIN);
  localparam logic [WIDTH-1:0]     MAX_V  = WIDTH'(POS_MAX);
  localparam logic signed [XW-1:0] MIN_X  = XW'(POS_MIN);
  localparam logic signed [XW-1:0] MAX_X  = XW'(POS_MAX);
  localparam logic signed [XW-1:0] SPAN_X = XW'(POS_MAX - POS_MIN + 1);
  localparam logic signed [XW-1:0] ACC_X  = XW'(ACCEL_STEP);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     run_q, run_d;
  logic              dir_q;
  logic              accept, quick, same_dir;
  logic signed [XW-1:0] step_x, pos_x, sum_x, new_x, ld_x, ldc_x;
  logic [WIDTH-1:0]  pos_d;

  // A count pulse only moves the position when neither a load nor an error claims the cycle.
  assign accept   = i_cnt & ~i_cnt_err & ~i_load;
  assign quick    = (timer_q < WIN);
  assign same_dir = (i_cnt_cw == dir_q);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= WIN;
      run_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      run_q   <= run_d;
      if (accept) dir_q <= i_cnt_cw;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    run_d   = run_q;
    if (i_load) begin
      state_d = IDLE;
      timer_d = WIN;
      run_d   = '0;
    end else if (accept) begin
      timer_d = '0;
      case (state_q)
        SLOW: begin
          if (quick && same_dir) begin
            run_d = RW'(run_q + 1'b1);
            if (RW'(run_q + 1'b1) == RUN_T) state_d = FAST;
          end else begin
            run_d = '0;
          end
        end
        FAST: begin
          if (!(quick && same_dir)) begin
            state_d = SLOW;
            run_d   = '0;
          end
        end
        default: begin
          state_d = SLOW;
          run_d   = '0;
        end
      endcase
    end else begin
      if (timer_q < WIN) timer_d = TW'(timer_q + 1'b1);
      // Errors and expired windows both drop acceleration back to rest.
      if (i_cnt_err || (timer_d == WIN)) begin
        state_d = IDLE;
        run_d   = '0;
      end
    end
  end

  // Output decode: step size for the pulse seen this cycle
  always_comb begin
    step_x = ONE_X;
    if ((state_q == FAST) && quick && same_dir) step_x = ACC_X;
  end

  // Position arithmetic in two extra bits so neither add nor subtract can overflow
  always_comb begin
    pos_x = $signed({2'b00, ov_pos});
    sum_x = i_cnt_cw ? (pos_x + step_x) : (pos_x - step_x);
    new_x = sum_x;
    if (WRAP != 0) begin
      if (sum_x > MAX_X)      new_x = sum_x - SPAN_X;
      else if (sum_x < MIN_X) new_x = sum_x + SPAN_X;
    end else begin
      if (sum_x > MAX_X)      new_x = MAX_X;
      else if (sum_x < MIN_X) new_x = MIN_X;
    end

    ld_x  = $signed({2'b00, iv_load_val});
    ldc_x = ld_x;
    if (ld_x > MAX_X)      ldc_x = MAX_X;
    else if (ld_x < MIN_X) ldc_x = MIN_X;

    pos_d = ov_pos;
    if (i_load)      pos_d = WIDTH'(ldc_x);
    else if (accept) pos_d = WIDTH'(new_x);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_pos     <= MIN_V;
      o_changed  <= 1'b0;
      ov_err_cnt <= '0;
    end else begin
      ov_pos    <= pos_d;
      o_changed <= (pos_d != ov_pos);
      if (i_err_clr)                       ov_err_cnt <= '0;
      else if (i_cnt_err && (ov_err_cnt != '1)) ov_err_cnt <= ov_err_cnt + 1'b1;
    end
  end

  assign o_at_min = (ov_pos == MIN_V);
  assign o_at_max = (ov_pos == MAX_V);

endmodule

// File: tb/tb_rotary_position_accumulator.sv
// Directed bench for rotary_position_accumulator. Five instances with
// different parameter sets share one stimulus stream; expectations are queued
// when stimulus is driven and compared just after the capturing clock edge.
module tb_rotary_position_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cnt, cw, cnt_err, load, err_clr;
  logic [7:0] load_val;

  // instance index: 0 default, 1 fast window, 2 wrap 0..9, 3 saturate 0..9, 4 err width 2
  logic [7:0] pos  [5];
  logic       chg  [5];
  logic       amin [5];
  logic       amax [5];
  logic [7:0] err  [4];
  logic [1:0] err_e;

  localparam int unsigned ID = 0, IA = 1, IW = 2, IS = 3, IE = 4;

  rotary_position_accumulator u_d (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(cnt_err),
    .i_load(load), .iv_load_val(load_val), .i_err_clr(err_clr),
    .ov_pos(pos[0]), .o_changed(chg[0]), .o_at_min(amin[0]), .o_at_max(amax[0]),
    .ov_err_cnt(err[0]));

  rotary_position_accumulator #(.ACCEL_WINDOW(16), .ACCEL_RUN(2), .ACCEL_STEP(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(cnt_err),
    .i_load(load), .iv_load_val(load_val), .i_err_clr(err_clr),
    .ov_pos(pos[1]), .o_changed(chg[1]), .o_at_min(amin[1]), .o_at_max(amax[1]),
    .ov_err_cnt(err[1]));

  rotary_position_accumulator #(.POS_MIN(0), .POS_MAX(9), .WRAP(1), .ACCEL_WINDOW(16)) u_w (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(cnt_err),
    .i_load(load), .iv_load_val(load_val), .i_err_clr(err_clr),
    .ov_pos(pos[2]), .o_changed(chg[2]), .o_at_min(amin[2]), .o_at_max(amax[2]),
    .ov_err_cnt(err[2]));

  rotary_position_accumulator #(.POS_MIN(0), .POS_MAX(9), .WRAP(0), .ACCEL_WINDOW(16)) u_s (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(cnt_err),
    .i_load(load), .iv_load_val(load_val), .i_err_clr(err_clr),
    .ov_pos(pos[3]), .o_changed(chg[3]), .o_at_min(amin[3]), .o_at_max(amax[3]),
    .ov_err_cnt(err[3]));

  rotary_position_accumulator #(.ERR_WIDTH(2), .ACCEL_WINDOW(16)) u_e (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(cnt_err),
    .i_load(load), .iv_load_val(load_val), .i_err_clr(err_clr),
    .ov_pos(pos[4]), .o_changed(chg[4]), .o_at_min(amin[4]), .o_at_max(amax[4]),
    .ov_err_cnt(err_e));

  // change strobes of instance 1, counted once per cycle
  int unsigned nchg_a = 0;
  always @(negedge clk) if (chg[1]) nchg_a <= nchg_a + 1;

  typedef enum int unsigned {F_POS, F_CHG, F_MIN, F_MAX, F_ERR, F_NCHG} field_t;
  typedef struct {
    string       tag;
    int unsigned inst;
    field_t      fld;
    int unsigned exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  function automatic int unsigned observe(int unsigned inst, field_t f);
    case (f)
      F_POS:   return int'(pos[inst]);
      F_CHG:   return int'(chg[inst]);
      F_MIN:   return int'(amin[inst]);
      F_MAX:   return int'(amax[inst]);
      F_ERR:   return (inst == IE) ? int'(err_e) : int'(err[inst]);
      default: return nchg_a;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unsigned inst, input field_t f,
                            input int unsigned v);
    sb.push_back('{tag: tag, inst: inst, fld: f, exp: v});
  endtask

  task automatic check_sb();
    while (sb.size() > 0) begin
      exp_t        e;
      int unsigned obs;
      e   = sb.pop_front();
      obs = observe(e.inst, e.fld);
      n_run++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // capture the driven inputs on the next edge, drop the strobes, compare
  task automatic go();
    tick();
    cnt = 1'b0; cw = 1'b0; cnt_err = 1'b0; load = 1'b0; err_clr = 1'b0;
    check_sb();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int unsigned exp_a [5];
    int unsigned exp_w [4];
    int unsigned exp_s [4];
    exp_a = '{1, 2, 3, 7, 11};
    exp_w = '{6, 7, 8, 2};
    exp_s = '{6, 7, 8, 9};

    rst = 1'b1; cnt = 1'b0; cw = 1'b0; cnt_err = 1'b0; load = 1'b0;
    err_clr = 1'b0; load_val = '0;

    // reset state, default parameters
    tick();
    expect_val("rst_pos", ID, F_POS, 0);
    expect_val("rst_chg", ID, F_CHG, 0);
    expect_val("rst_min", ID, F_MIN, 1);
    expect_val("rst_max", ID, F_MAX, 0);
    expect_val("rst_err", ID, F_ERR, 0);
    check_sb();
    rst = 1'b0;
    idle(2);

    // slow pulses, 20 cycles apart
    base = nchg_a;
    for (int k = 1; k <= 3; k++) begin
      cnt = 1'b1; cw = 1'b1;
      expect_val("slow_pos", IA, F_POS, k);
      expect_val("slow_chg", IA, F_CHG, 1);
      go();
      idle(19);
    end
    expect_val("slow_nchg", IA, F_NCHG, base + 3);
    expect_val("slow_chg_off", IA, F_CHG, 0);
    check_sb();

    // acceleration: quick pulses 4 cycles apart
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cnt = 1'b1; cw = 1'b1;
      expect_val("accel_pos", IA, F_POS, exp_a[k]);
      go();
      idle(3);
    end
    cnt = 1'b1; cw = 1'b0;
    expect_val("accel_ccw", IA, F_POS, 10);
    go();
    idle(16);
    cnt = 1'b1; cw = 1'b1;
    expect_val("accel_after_idle", IA, F_POS, 11);
    go();
    for (int k = 0; k < 3; k++) begin
      idle(3);
      cnt = 1'b1; cw = 1'b1;
      expect_val("refast_pos", IA, F_POS, (k == 2) ? 17 : 12 + k);
      go();
    end

    // asynchronous reset in the middle of a cycle while in FAST
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_val("async_rst_pos", IA, F_POS, 0);
    expect_val("async_rst_min", IA, F_MIN, 1);
    check_sb();
    tick();
    rst = 1'b0;
    idle(1);
    cnt = 1'b1; cw = 1'b1;
    expect_val("post_rst_step", IA, F_POS, 1);
    go();

    // bounds: wrap and saturate on 0..9
    do_reset();
    load = 1'b1; load_val = 8'd9;
    expect_val("bnd_load_w", IW, F_POS, 9);
    expect_val("bnd_load_s", IS, F_POS, 9);
    go();
    cnt = 1'b1; cw = 1'b1;
    expect_val("wrap_hi_pos", IW, F_POS, 0);
    expect_val("wrap_hi_chg", IW, F_CHG, 1);
    expect_val("wrap_hi_min", IW, F_MIN, 1);
    expect_val("sat_hi_pos", IS, F_POS, 9);
    expect_val("sat_hi_chg", IS, F_CHG, 0);
    expect_val("sat_hi_max", IS, F_MAX, 1);
    go();
    idle(3);
    cnt = 1'b1; cw = 1'b0;
    expect_val("wrap_lo_pos", IW, F_POS, 9);
    expect_val("sat_dec_pos", IS, F_POS, 8);
    go();
    load = 1'b1; load_val = 8'd5;
    expect_val("bnd_load5_w", IW, F_POS, 5);
    go();
    idle(2);
    for (int k = 0; k < 4; k++) begin
      cnt = 1'b1; cw = 1'b1;
      expect_val("wrap_fast_pos", IW, F_POS, exp_w[k]);
      expect_val("sat_fast_pos", IS, F_POS, exp_s[k]);
      go();
      idle(3);
    end

    // decoder errors
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      cnt = 1'b1; cw = 1'b1;
      expect_val("err_pre_pos", IA, F_POS, k);
      go();
      if (k < 3) idle(3);
    end
    idle(1);
    for (int k = 1; k <= 3; k++) begin
      cnt_err = 1'b1;
      expect_val("err_cnt_a", IA, F_ERR, k);
      expect_val("err_cnt_e", IE, F_ERR, k);
      go();
    end
    idle(1);
    cnt = 1'b1; cw = 1'b1;
    expect_val("err_idle_step", IA, F_POS, 4);
    go();
    idle(1);
    cnt = 1'b1; cw = 1'b1; cnt_err = 1'b1;
    expect_val("err_cnt_pos", IA, F_POS, 4);
    expect_val("err_cnt_chg", IA, F_CHG, 0);
    expect_val("err_cnt4_a", IA, F_ERR, 4);
    expect_val("err_sat4_e", IE, F_ERR, 3);
    go();
    cnt_err = 1'b1;
    expect_val("err_cnt5_a", IA, F_ERR, 5);
    expect_val("err_sat5_e", IE, F_ERR, 3);
    go();
    cnt_err = 1'b1; err_clr = 1'b1;
    expect_val("err_clr_a", IA, F_ERR, 0);
    expect_val("err_clr_e", IE, F_ERR, 0);
    go();

    // preload
    do_reset();
    load = 1'b1; load_val = 8'd12;
    expect_val("load_clamp_pos", IW, F_POS, 9);
    expect_val("load_clamp_chg", IW, F_CHG, 1);
    expect_val("load_wide_pos", IA, F_POS, 12);
    go();
    load = 1'b1; load_val = 8'd9;
    expect_val("load_same_pos", IW, F_POS, 9);
    expect_val("load_same_chg", IW, F_CHG, 0);
    go();
    idle(2);
    for (int k = 0; k < 3; k++) begin
      cnt = 1'b1; cw = 1'b1;
      expect_val("load_pre_pos", IW, F_POS, k);
      go();
      idle(3);
    end
    load = 1'b1; load_val = 8'd3; cnt = 1'b1; cw = 1'b1;
    expect_val("load_vs_cnt_pos", IW, F_POS, 3);
    expect_val("load_vs_cnt_chg", IW, F_CHG, 1);
    go();
    idle(3);
    cnt = 1'b1; cw = 1'b1;
    expect_val("load_idle_step", IW, F_POS, 4);
    go();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
